// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IROM addressing and an in-order
// {pc, instr} queue drained by decode through a valid/ready handshake.
module fetch_unit #(
  parameter int AW    = 5,
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [AW-1:0]            irom_addr,
  input  logic [W-1:0]             irom_data,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_instr,
  output logic [AW-1:0]            out_pc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [AW-1:0] PC_ONE  = AW'(1);

  logic [AW-1:0] pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic          pop;
  logic          push;

  logic [AW-1:0] ent_pc    [DEPTH];
  logic [W-1:0]  ent_instr [DEPTH];

  always_comb begin
    pop  = out_valid & out_ready;
    push = !redirect & ((count < FULL) | pop);
  end

  // Redirect outranks push and pop: a same-cycle pop is simply flushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      pc    <= redirect_pc;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc   <= pc + PC_ONE;
        tail <= tail + PTR_ONE;
      end
      if (pop) head <= head + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; visibility is gated by count.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      ent_pc[tail]    <= pc;
      ent_instr[tail] <= irom_data;
    end
  end

  always_comb begin
    irom_addr = pc;
    q_count   = count;
    out_valid = (count != '0);
    out_instr = out_valid ? ent_instr[head] : '0;
    out_pc    = out_valid ? ent_pc[head] : '0;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: straight-line fetch, backpressure,
// full push/pop, redirect, PC wrap and asynchronous reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  irom_addr;
  logic [31:0] irom_data;
  logic        redirect;
  logic [4:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [4:0]  out_pc;
  logic [2:0]  q_count;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.AW(5), .W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .irom_addr(irom_addr), .irom_data(irom_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [4:0] a);
    case (a)
      5'd0:    rom = 32'h8C010000;
      5'd1:    rom = 32'h8C020001;
      5'd2:    rom = 32'h00221820;
      5'd3:    rom = 32'hAC030002;
      default: rom = 32'h0;
    endcase
  endfunction

  assign irom_data = rom(irom_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    #12;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    reset = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    #3;
    total++;
    if ({out_valid, q_count, irom_addr, out_pc, out_instr} !== '0) begin
      bad++;
      $display("FAIL reset_state: valid=%0b cnt=%0d addr=%0d pc=%0d instr=%h, required all 0",
               out_valid, q_count, irom_addr, out_pc, out_instr);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL cycle0_valid: got %0b required 0", out_valid);
    end
  endtask

  task automatic test_straight();
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_pc !== 5'(i) || out_instr !== rom(5'(i)) || q_count !== 3'd1) begin
        bad++;
        $display("FAIL straight[%0d]: valid=%0b pc=%0d instr=%h cnt=%0d, required 1 %0d %h 1",
                 i, out_valid, out_pc, out_instr, q_count, i, rom(5'(i)));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] exp_cnt [6];
    logic [4:0] exp_addr [6];
    exp_cnt  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    exp_addr = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd4, 5'd4};
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (q_count !== exp_cnt[i] || irom_addr !== exp_addr[i] || out_pc !== 5'd0) begin
        bad++;
        $display("FAIL bp_fill[%0d]: cnt=%0d addr=%0d head=%0d, required %0d %0d 0",
                 i, q_count, irom_addr, out_pc, exp_cnt[i], exp_addr[i]);
      end
    end
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_pc !== 5'(i) || out_instr !== rom(5'(i))) begin
        bad++;
        $display("FAIL bp_drain[%0d]: valid=%0b pc=%0d instr=%h, required 1 %0d %h",
                 i, out_valid, out_pc, out_instr, i, rom(5'(i)));
      end
      step();
    end
  endtask

  task automatic test_full_pushpop();
    out_ready = 1'b0;
    do_reset();
    repeat (4) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    total++;
    if (q_count !== 3'd4 || out_pc !== 5'd1 || out_instr !== rom(5'd1) || irom_addr !== 5'd5) begin
      bad++;
      $display("FAIL full_pushpop: cnt=%0d head=%0d instr=%h addr=%0d, required 4 1 %h 5",
               q_count, out_pc, out_instr, irom_addr, rom(5'd1));
    end
    step();
    total++;
    if (q_count !== 3'd4 || out_pc !== 5'd1 || out_instr !== rom(5'd1) || irom_addr !== 5'd5) begin
      bad++;
      $display("FAIL full_stall: cnt=%0d head=%0d instr=%h addr=%0d, required 4 1 %h 5",
               q_count, out_pc, out_instr, irom_addr, rom(5'd1));
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    do_reset();
    repeat (3) step();
    total++;
    if (q_count !== 3'd3 || irom_addr !== 5'd3) begin
      bad++;
      $display("FAIL redir_pre: cnt=%0d addr=%0d, required 3 3", q_count, irom_addr);
    end
    redirect = 1'b1;
    redirect_pc = 5'd2;
    step();
    redirect = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || q_count !== 3'd0 || irom_addr !== 5'd2 || out_pc !== 5'd0 || out_instr !== 32'h0) begin
      bad++;
      $display("FAIL redir_flush: valid=%0b cnt=%0d addr=%0d pc=%0d instr=%h, required 0 0 2 0 0",
               out_valid, q_count, irom_addr, out_pc, out_instr);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 5'd2 || out_instr !== 32'h00221820 || q_count !== 3'd1) begin
      bad++;
      $display("FAIL redir_first: valid=%0b pc=%0d instr=%h cnt=%0d, required 1 2 00221820 1",
               out_valid, out_pc, out_instr, q_count);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] exp_pc [4];
    exp_pc = '{5'd30, 5'd31, 5'd0, 5'd1};
    out_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 5'd30;
    step();
    redirect = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || irom_addr !== 5'd30) begin
      bad++;
      $display("FAIL wrap_redir: valid=%0b addr=%0d, required 0 30", out_valid, irom_addr);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_instr !== rom(exp_pc[i])) begin
        bad++;
        $display("FAIL wrap[%0d]: valid=%0b pc=%0d instr=%h, required 1 %0d %h",
                 i, out_valid, out_pc, out_instr, exp_pc[i], rom(exp_pc[i]));
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    do_reset();
    repeat (2) step();
    total++;
    if (q_count !== 3'd2) begin
      bad++;
      $display("FAIL arst_pre: cnt=%0d required 2", q_count);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || irom_addr !== 5'd0 || q_count !== 3'd0 || out_pc !== 5'd0 || out_instr !== 32'h0) begin
      bad++;
      $display("FAIL arst_immediate: valid=%0b addr=%0d cnt=%0d pc=%0d instr=%h, required all 0",
               out_valid, irom_addr, q_count, out_pc, out_instr);
    end
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 5'd0 || out_instr !== 32'h8C010000 || q_count !== 3'd1 || irom_addr !== 5'd1) begin
      bad++;
      $display("FAIL arst_resume: valid=%0b pc=%0d instr=%h cnt=%0d addr=%0d, required 1 0 8c010000 1 1",
               out_valid, out_pc, out_instr, q_count, irom_addr);
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_backpressure();
    test_full_pushpop();
    test_redirect();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the MIPS datapath. Holds the program counter, drives the word address of the instruction ROM, and captures each returned instruction with its PC into a small in-order queue. Decode drains the queue through a valid/ready handshake. A redirect from branch resolution flushes the queue and restarts fetch at a new PC.

## Interface
- AW, 5, PC and IROM word-address width; the PC wraps modulo 2**AW.
- W, 32, instruction width.
- DEPTH, 4, instruction queue entries; must be a power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- irom_addr  out  AW  word address presented to the instruction ROM.
- irom_data  in  W  ROM read data; combinational from irom_addr and valid before the next rising edge.
- redirect  in  1  flush the queue and load the PC from redirect_pc.
- redirect_pc  in  AW  new fetch address.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  W  instruction at the queue head.
- out_pc  out  AW  PC of out_instr.
- q_count  out  log2(DEPTH)+1  number of occupied entries.

## Operation
- State:
  - pc (AW bits)
  - circular queue of DEPTH entries holding {pc, instr}
  - head pointer, tail pointer and count
- irom_addr = pc, driven directly from the register.
- Per-cycle terms:
  - pop = out_valid & out_ready
  - push = !redirect & (count < DEPTH | pop)
- On push:
  - Write entry[tail] = {pc, irom_data}.
  - tail := tail+1 mod DEPTH.
  - pc := pc+1 mod 2**AW; 31 wraps to 0 with no error.
- On pop (no redirect): head := head+1 mod DEPTH.
- Count update: count := count + push − pop. Push and pop in the same cycle leave count unchanged. Push is allowed when full only if a pop happens in the same cycle.
- out_valid = (count != 0).
- out_instr and out_pc show entry[head] when out_valid=1 and are forced to 0 when out_valid=0.
- Redirect has priority over everything else:
  - count, head and tail := 0.
  - pc := redirect_pc.
  - No push that cycle. A pop handshaking in the same cycle completes from decode's point of view but has no further effect; everything is flushed.
- The queue is strictly in order. Instructions are never dropped or duplicated except by redirect.
- The block does not decode instructions. A value of 0 (nop) is queued like any other instruction.

## Timing
- Reset asserted: pc=0, count=0, head=tail=0, out_valid=0, out_instr=0, out_pc=0, q_count=0, irom_addr=0. All of these take effect immediately, independent of clk.
- Reset asserted in the middle of operation discards all queued entries. The first edge after deassertion fetches address 0.
- Fetch-to-decode latency is one edge: the instruction at pc is captured at edge N and out_valid is high after edge N.
- Throughput: with out_ready held at 1, one instruction per cycle, and count stays at 1.
- With out_ready=0, the queue fills after DEPTH edges. The PC then stops advancing and irom_addr holds the next unfetched address.
- Redirect at edge N:
  - out_valid=0 and irom_addr=redirect_pc after edge N.
  - The first instruction from the new path appears after edge N+1, so the redirect penalty is one bubble.
- Redirect while full, while empty, or with redirect_pc equal to the current pc: the behaviour is identical in all three cases.
- out_instr and out_pc are stable whenever out_valid=1 and out_ready=0.

## Test plan
- **Reset and straight-line fetch.** Bench IROM: 0→0x8C010000, 1→0x8C020001, 2→0x00221820, 3→0xAC030002, others 0. Release reset with out_ready=1. Required: out_valid is 0 in cycle 0. Then (out_pc, out_instr) = (0,0x8C010000), (1,0x8C020001), (2,0x00221820), (3,0xAC030002), (4,0) on consecutive cycles.
- **Backpressure.** Hold out_ready=0 for 6 cycles. Required: q_count goes 1,2,3,4,4,4, and irom_addr holds at 4. Raise out_ready: PCs 0,1,2,3,4,5 drain in order with no gap.
- **Simultaneous push/pop when full.** With count=4, pulse out_ready for 1 cycle. Required: count stays 4, the head advances by one, and the PC advances by one.
- **Redirect.** Pulse redirect with redirect_pc=2 while 3 entries are queued. Required: the next cycle shows out_valid=0, q_count=0 and irom_addr=2. The cycle after shows out_pc=2 with out_instr=0x00221820.
- **Wrap-around.** Issue a redirect to 30 with out_ready=1. Required: out_pc sequence 30, 31, 0, 1 with correct data.
- **Asynchronous reset mid-stream.** Assert reset between edges with 2 entries queued. Required: out_valid=0 and irom_addr=0 immediately, before any clock edge. Fetch resumes at PC 0 after release.
